pc_redirect_ctrl: RTL and testbench

- Control-side driver of the program counter interface: produces the PC write enable `en`, next-PC select `sel` and jump target `jump_a`.
- The PC block consumes these together with datapath-supplied `ext32` and `jr_a`.
- Arbitrates redirects: branch/JR resolved in EX, J decoded in ID.
- Holds a redirect pending until the fetch stage can accept a PC write; issues pipeline flush/hold and halt control.

---
 rtl/pc_redirect_ctrl_if.sv | 32 +++
 rtl/pc_redirect_ctrl.sv | 143 ++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pc_redirect_ctrl_if.sv
// rtl/pc_redirect_ctrl_if.sv - PC redirect control bus between pipeline and redirect controller
interface pc_redirect_ctrl_if #(
  parameter int ADDR_W = 26
);
  logic              ihit;
  logic              stall;
  logic              br_valid;
  logic              br_taken;
  logic              jr_valid;
  logic              j_valid;
  logic [ADDR_W-1:0] j_target;
  logic              halt_req;
  logic              en;
  logic [1:0]        sel;
  logic [ADDR_W-1:0] jump_a;
  logic              flush_if;
  logic              flush_id;
  logic              hold_ex;
  logic              halted;

  // Controller side: consumes pipeline status, drives PC and flush/hold controls.
  modport master (
    input  ihit, stall, br_valid, br_taken, jr_valid, j_valid, j_target, halt_req,
    output en, sel, jump_a, flush_if, flush_id, hold_ex, halted
  );

  // Pipeline side: supplies status, observes PC and flush/hold controls.
  modport slave (
    output ihit, stall, br_valid, br_taken, jr_valid, j_valid, j_target, halt_req,
    input  en, sel, jump_a, flush_if, flush_id, hold_ex, halted
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - PC write enable, next-PC select and redirect arbitration
module pc_redirect_ctrl #(
  parameter int ADDR_W = 26
) (
  input logic                CLK,
  input logic                RST,
  pc_redirect_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_PEND = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [1:0] SEL_NPC = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_J   = 2'b10;
  localparam logic [1:0] SEL_JR  = 2'b11;

  state_t            state_q, state_d;
  logic [1:0]        pend_sel_q, pend_sel_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              halted_q, halted_d;

  logic              wo;
  logic              br_req;
  logic              ex_req;
  logic              any_req;
  logic [1:0]        req_sel;
  logic [ADDR_W-1:0] req_tgt;

  logic              en_c;
  logic [1:0]        sel_c;
  logic [ADDR_W-1:0] jump_a_c;
  logic              flush_if_c;
  logic              flush_id_c;
  logic              hold_ex_c;

  // Request arbitration: EX-stage redirects beat the (wrong-path) ID jump.
  always_comb begin
    wo      = bus.ihit & ~bus.stall;
    br_req  = bus.br_valid & bus.br_taken;
    ex_req  = br_req | bus.jr_valid;
    any_req = ex_req | bus.j_valid;
    req_sel = SEL_NPC;
    if (br_req)            req_sel = SEL_BR;
    else if (bus.jr_valid) req_sel = SEL_JR;
    else if (bus.j_valid)  req_sel = SEL_J;
    req_tgt = (req_sel == SEL_J) ? bus.j_target : '0;
  end

  // Next-state and combinational PC/flush/hold controls; reset forces everything idle.
  always_comb begin
    state_d    = state_q;
    pend_sel_d = pend_sel_q;
    pend_tgt_d = pend_tgt_q;
    en_c       = 1'b0;
    sel_c      = SEL_NPC;
    jump_a_c   = '0;
    flush_if_c = 1'b0;
    flush_id_c = 1'b0;
    hold_ex_c  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (bus.halt_req) begin
          flush_if_c = 1'b1;
          flush_id_c = 1'b1;
          state_d    = ST_HALT;
        end else if (any_req) begin
          sel_c    = req_sel;
          jump_a_c = req_tgt;
          if (wo) begin
            en_c       = 1'b1;
            flush_if_c = 1'b1;
            flush_id_c = ex_req;
          end else begin
            // Fetch cannot take the write yet: remember it and freeze EX operands.
            hold_ex_c  = ex_req;
            pend_sel_d = req_sel;
            pend_tgt_d = req_tgt;
            state_d    = ST_PEND;
          end
        end else begin
          en_c = wo;
        end
      end
      ST_PEND: begin
        // sel bit 0 set means BR or JR, i.e. the redirect came from EX.
        sel_c     = pend_sel_q;
        jump_a_c  = pend_tgt_q;
        hold_ex_c = pend_sel_q[0];
        if (wo) begin
          en_c       = 1'b1;
          flush_if_c = 1'b1;
          flush_id_c = pend_sel_q[0];
          pend_sel_d = SEL_NPC;
          pend_tgt_d = '0;
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    halted_d = (state_d == ST_HALT);

    if (RST) begin
      state_d    = ST_RUN;
      pend_sel_d = SEL_NPC;
      pend_tgt_d = '0;
      halted_d   = 1'b0;
      en_c       = 1'b0;
      sel_c      = SEL_NPC;
      jump_a_c   = '0;
      flush_if_c = 1'b0;
      flush_id_c = 1'b0;
      hold_ex_c  = 1'b0;
    end
  end

  // State, pending redirect and halted flag registers (reset folded into _d above).
  always_ff @(posedge CLK) begin
    state_q    <= state_d;
    pend_sel_q <= pend_sel_d;
    pend_tgt_q <= pend_tgt_d;
    halted_q   <= halted_d;
  end

  // Drive the bus.
  always_comb begin
    bus.en       = en_c;
    bus.sel      = sel_c;
    bus.jump_a   = jump_a_c;
    bus.flush_if = flush_if_c;
    bus.flush_id = flush_id_c;
    bus.hold_ex  = hold_ex_c;
    bus.halted   = halted_q;
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed self-checking bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;
  localparam int ADDR_W = 26;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  pc_redirect_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  pc_redirect_ctrl #(.ADDR_W(ADDR_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_en, input logic [1:0] e_sel,
                         input logic e_fi, input logic e_fd, input logic e_hold);
    #2;
    chk({tag, ".en"},       {31'd0, bus.en},       {31'd0, e_en});
    chk({tag, ".sel"},      {30'd0, bus.sel},      {30'd0, e_sel});
    chk({tag, ".flush_if"}, {31'd0, bus.flush_if}, {31'd0, e_fi});
    chk({tag, ".flush_id"}, {31'd0, bus.flush_id}, {31'd0, e_fd});
    chk({tag, ".hold_ex"},  {31'd0, bus.hold_ex},  {31'd0, e_hold});
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    RST          = 1'b1;
    bus.ihit     = 1'b1;
    bus.stall    = 1'b0;
    bus.br_valid = 1'b0;
    bus.br_taken = 1'b0;
    bus.jr_valid = 1'b0;
    bus.j_valid  = 1'b0;
    bus.j_target = '0;
    bus.halt_req = 1'b0;

    // Reset held two cycles with ihit high
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out("reset", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      chk("reset.halted", {31'd0, bus.halted}, 32'd0);
      chk("reset.jump_a", {6'd0, bus.jump_a}, 32'd0);
    end
    tick();
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk_out("run_npc", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
      tick();
    end

    // Taken branch with write opportunity
    bus.br_valid = 1'b1; bus.br_taken = 1'b1;
    chk_out("br_taken", 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    tick();
    bus.br_valid = 1'b0; bus.br_taken = 1'b0;
    chk_out("br_after", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();

    // JR pending for three cycles, then commits
    bus.jr_valid = 1'b1; bus.ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_out("jr_pend", 1'b0, 2'b11, 1'b0, 1'b0, 1'b1);
      tick();
    end
    bus.ihit = 1'b1;
    chk_out("jr_commit", 1'b1, 2'b11, 1'b1, 1'b1, 1'b1);
    tick();
    bus.jr_valid = 1'b0;
    chk_out("jr_after", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();

    // Priority: taken branch masks same-cycle J
    bus.br_valid = 1'b1; bus.br_taken = 1'b1;
    bus.j_valid = 1'b1; bus.j_target = 26'h0ABCDEF;
    chk_out("prio_br", 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    chk("prio_br.jump_a", {6'd0, bus.jump_a}, 32'd0);
    tick();
    // Untaken branch does not mask J
    bus.br_taken = 1'b0;
    chk_out("prio_j", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    chk("prio_j.jump_a", {6'd0, bus.jump_a}, 32'h0ABCDEF);
    tick();
    bus.br_valid = 1'b0; bus.j_valid = 1'b0;

    // Stall blocks the J write even with ihit high
    bus.stall = 1'b1; bus.j_valid = 1'b1; bus.j_target = 26'h0001234;
    chk_out("stall_j", 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    tick();
    bus.stall = 1'b0;
    bus.br_valid = 1'b1; bus.br_taken = 1'b1;
    bus.j_target = 26'h0000077;
    chk_out("stall_commit", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    chk("stall_commit.jump_a", {6'd0, bus.jump_a}, 32'h1234);
    tick();
    bus.j_valid = 1'b0; bus.br_valid = 1'b0; bus.br_taken = 1'b0;
    chk_out("stall_after", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();

    // Halt: flush on entry, halted registered from the next cycle
    bus.halt_req = 1'b1;
    chk_out("halt_entry", 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("halt_entry.halted", {31'd0, bus.halted}, 32'd0);
    tick();
    bus.halt_req = 1'b0;
    bus.j_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk_out("halted", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      chk("halted.halted", {31'd0, bus.halted}, 32'd1);
      tick();
    end
    bus.j_valid = 1'b0;
    RST = 1'b1;
    tick();
    chk("halt_rst.halted", {31'd0, bus.halted}, 32'd0);
    RST = 1'b0;
    chk_out("halt_rst_run", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();

    // Reset while a JR redirect is pending
    bus.ihit = 1'b0; bus.jr_valid = 1'b1;
    chk_out("pend_rst_latch", 1'b0, 2'b11, 1'b0, 1'b0, 1'b1);
    tick();
    RST = 1'b1;
    chk_out("pend_rst_hold", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    RST = 1'b0; bus.jr_valid = 1'b0; bus.ihit = 1'b1;
    chk_out("pend_rst_run", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    bus.ihit = 1'b0;
    chk_out("pend_rst_noihit", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
